phys_reg_free_list: RTL and testbench
=====================================

// Module: phys_reg_free_list
// PURPOSE
//  Supplies free physical register tags to the renaming map and reclaims tags released at commit.
//  It is the producer end of the rename interface: renaming_map consumes one free tag per renamed rd.
//  The commit path returns each superseded physical tag here.
//  Circular FIFO of free tags, plus a per-tag "is free" bitmap that detects illegal releases.
// PARAMETERS
//  ARCH_REG_WIDTH  5  arch reg index width; NUM_ARCH = 2**ARCH_REG_WIDTH
//  PHYS_REG_WIDTH  6  phys reg tag width; NUM_PHYS = 2**PHYS_REG_WIDTH; must be > ARCH_REG_WIDTH
//  (derived) DEPTH = NUM_PHYS - NUM_ARCH; CW = $clog2(DEPTH+1)
// PORTS
//  clk_i          in   1               clock, all state on rising edge
//  rst_i          in   1               synchronous reset, active-high
//  alloc_req_i    in   1               rename requests one free tag this cycle
//  alloc_valid_o  out  1               free list non-empty; alloc_preg_o is meaningful
//  alloc_preg_o   out  PHYS_REG_WIDTH  tag at FIFO head (show-ahead)
//  alloc_gnt_o    out  1               alloc_req_i && alloc_valid_o; tag consumed this cycle
//  rel_valid_i    in   1               commit releases a tag this cycle
//  rel_preg_i     in   PHYS_REG_WIDTH  tag being released
//  free_count_o   out  CW              number of tags currently in the list
//  rel_err_o      out  1               one-cycle pulse: the previous-cycle release was rejected
// BEHAVIOUR
//  Reset (sync, rst_i=1 at posedge); this takes priority over every other input:
//  - fifo[i] = NUM_ARCH+i for i in 0..DEPTH-1; head = 0; tail = 0 (wrapped); count = DEPTH
//  - bitmap[p] = 1 for p >= NUM_ARCH, else 0; outputs settle to alloc_valid_o=1,
//    alloc_preg_o=NUM_ARCH, free_count_o=DEPTH, alloc_gnt_o=0, rel_err_o=0
//  Allocate (0-cycle latency):
//  - alloc_valid_o = (count != 0); alloc_preg_o = fifo[head]; alloc_gnt_o is combinational
//  - on grant: head <= head+1 mod DEPTH; bitmap[alloc_preg_o] <= 0
//  - request while empty: no grant, no state change; rename must stall (no bypass from release)
//  Release (1-cycle latency to visibility):
//  - accepted iff rel_valid_i && rel_preg_i != 0 && bitmap[rel_preg_i] == 0 && (count - gnt) < DEPTH
//  - accepted: fifo[tail] <= rel_preg_i; tail <= tail+1 mod DEPTH; bitmap[rel_preg_i] <= 1
//  - rejected (tag 0, double free, overflow): no state change; rel_err_o <= 1 for the next cycle only
//  Simultaneous grant and accepted release: count unchanged. The released tag is never the
//  granted tag, because the bitmap rejects a release of a tag that is already free.
//  count <= count - gnt + accepted_release; head and tail wrap independently at DEPTH.
//  An empty-cycle release becomes alloc_preg_o the following cycle (alloc_valid_o rises then).
//  Reset mid-operation discards all in-flight state and restores the reset image above.
// TESTING
//  1 reset, idle -> alloc_valid_o=1, alloc_preg_o=32, free_count_o=32, rel_err_o=0
//  2 alloc_req_i=1 for 33 cycles -> grants 32,33..63 in order; cycle 33: gnt=0, valid=0, count=0
//  3 from empty, release p5 -> next cycle alloc_valid_o=1, alloc_preg_o=5, count=1; then grant 5
//  4 after 1 alloc (count=31), alloc+release p7 same cycle -> gnt tag 33, count stays 31, p7 queued at tail
//  5 release p40 while p40 free -> rel_err_o=1 one cycle, count unchanged;
//    release p0 -> rel_err_o=1, ignored
//  6 after 10 grants and 3 releases, assert rst_i one cycle -> state equals test 1 next cycle

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Free physical register tag pool for rename: circular FIFO of free tags with show-ahead
// allocation, plus a per-tag free bitmap that rejects releases of tag 0, double frees and overflow.
module phys_reg_free_list #(
   parameter int ARCH_REG_WIDTH = 5,
   parameter int PHYS_REG_WIDTH = 6,
   localparam int NUM_ARCH = 2 ** ARCH_REG_WIDTH,
   localparam int NUM_PHYS = 2 ** PHYS_REG_WIDTH,
   localparam int DEPTH    = NUM_PHYS - NUM_ARCH,
   localparam int CW       = $clog2(DEPTH + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      alloc_req_i,
   output logic                      alloc_valid_o,
   output logic [PHYS_REG_WIDTH-1:0] alloc_preg_o,
   output logic                      alloc_gnt_o,
   input  logic                      rel_valid_i,
   input  logic [PHYS_REG_WIDTH-1:0] rel_preg_i,
   output logic [CW-1:0]             free_count_o,
   output logic                      rel_err_o
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Handshake: a tag is transferred on any cycle where alloc_req_i and alloc_valid_o are both
   // high (alloc_gnt_o); alloc_preg_o is stable while alloc_valid_o is high and no grant occurs.
   // Releases have no back-pressure; a rejected release is flagged on rel_err_o one cycle later.

   logic [PHYS_REG_WIDTH-1:0] fifo [DEPTH];
   logic [NUM_PHYS-1:0]       bitmap;
   logic [IW-1:0]             head;
   logic [IW-1:0]             tail;
   logic [CW-1:0]             count;
   logic                      gnt;
   logic                      rel_ok;
   logic [CW-1:0]             count_after_gnt;

   assign alloc_valid_o = (count != '0);
   assign alloc_preg_o  = fifo[head];
   assign gnt           = alloc_req_i && alloc_valid_o;
   assign alloc_gnt_o   = gnt;
   assign free_count_o  = count;

   // The overflow test uses the post-grant occupancy so a full list can still absorb a
   // release in the same cycle it hands out a tag.
   assign count_after_gnt = count - CW'(gnt);
   assign rel_ok = rel_valid_i && (rel_preg_i != '0) && !bitmap[rel_preg_i]
                   && (count_after_gnt < CW'(DEPTH));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo[i] <= PHYS_REG_WIDTH'(NUM_ARCH + i);
         end
         for (int p = 0; p < NUM_PHYS; p++) begin
            bitmap[p] <= (p >= NUM_ARCH);
         end
         head      <= '0;
         tail      <= '0;
         count     <= CW'(DEPTH);
         rel_err_o <= 1'b0;
      end else begin
         if (gnt) begin
            head                 <= (head == IW'(DEPTH - 1)) ? '0 : head + 1'b1;
            bitmap[alloc_preg_o] <= 1'b0;
         end
         // A granted tag is still marked free this cycle, so it can never equal rel_preg_i here.
         if (rel_ok) begin
            fifo[tail]         <= rel_preg_i;
            tail               <= (tail == IW'(DEPTH - 1)) ? '0 : tail + 1'b1;
            bitmap[rel_preg_i] <= 1'b1;
         end
         count     <= count_after_gnt + CW'(rel_ok);
         rel_err_o <= rel_valid_i && !rel_ok;
      end
   end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Bench for phys_reg_free_list: directed scenarios plus random traffic, checked by a
// queue-and-set reference model through scoreboard queues popped by a negedge monitor.
module tb_phys_reg_free_list;

  localparam int W        = 6;
  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int DEPTH    = 32;

  typedef struct {
    logic         valid;
    logic [W-1:0] preg;
    logic [W-1:0] count;
    logic         err;
    logic         gnt;
  } status_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         alloc_req = 1'b0;
  logic         alloc_valid;
  logic [W-1:0] alloc_preg;
  logic         alloc_gnt;
  logic         rel_valid = 1'b0;
  logic [W-1:0] rel_preg = '0;
  logic [W-1:0] free_count;
  logic         rel_err;

  logic [W-1:0] exp_q[$];
  status_t      stat_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  // reference model: ordered list of free tags plus a free flag per tag
  int           m_list[$];
  bit           m_free[NUM_PHYS];
  bit           m_err;

  phys_reg_free_list dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .alloc_req_i  (alloc_req),
    .alloc_valid_o(alloc_valid),
    .alloc_preg_o (alloc_preg),
    .alloc_gnt_o  (alloc_gnt),
    .rel_valid_i  (rel_valid),
    .rel_preg_i   (rel_preg),
    .free_count_o (free_count),
    .rel_err_o    (rel_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic model_reset();
    m_list.delete();
    for (int i = NUM_ARCH; i < NUM_PHYS; i++) m_list.push_back(i);
    for (int p = 0; p < NUM_PHYS; p++) m_free[p] = (p >= NUM_ARCH);
    m_err = 1'b0;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    alloc_req = 1'b0;
    rel_valid = 1'b0;
    rel_preg  = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // driver: one cycle of stimulus; expectations come from the model before it is advanced
  task automatic step(input logic req, input logic rv, input logic [W-1:0] rp);
    status_t s;
    bit      g;
    bit      acc;
    alloc_req = req;
    rel_valid = rv;
    rel_preg  = rp;
    g       = req && (m_list.size() != 0);
    s.valid = (m_list.size() != 0);
    s.preg  = (m_list.size() != 0) ? W'(m_list[0]) : '0;
    s.count = W'(m_list.size());
    s.err   = m_err;
    s.gnt   = g;
    stat_q.push_back(s);
    if (g) exp_q.push_back(W'(m_list[0]));
    acc = rv && (rp != 0) && !m_free[rp] && ((m_list.size() - int'(g)) < DEPTH);
    if (g) begin
      m_free[m_list[0]] = 1'b0;
      void'(m_list.pop_front());
    end
    if (acc) begin
      m_list.push_back(int'(rp));
      m_free[rp] = 1'b1;
    end
    m_err = rv && !acc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  initial begin
    status_t s;
    logic [W-1:0] t;
    forever begin
      @(negedge clk);
      if (stat_q.size() != 0) begin
        s = stat_q.pop_front();
        check("alloc_valid", int'(alloc_valid), int'(s.valid));
        check("free_count", int'(free_count), int'(s.count));
        check("rel_err", int'(rel_err), int'(s.err));
        check("alloc_gnt", int'(alloc_gnt), int'(s.gnt));
        if (s.valid) check("alloc_preg", int'(alloc_preg), int'(s.preg));
        if (s.gnt && exp_q.size() != 0) begin
          t = exp_q.pop_front();
          if (alloc_gnt) check("grant_tag", int'(alloc_preg), int'(t));
        end
      end
    end
  end

  function automatic logic [W-1:0] pick_release();
    int start;
    start = $urandom_range(0, NUM_PHYS - 1);
    if ($urandom_range(0, 3) == 0) return W'(start);
    for (int k = 0; k < NUM_PHYS; k++) begin
      if (!m_free[(start + k) % NUM_PHYS]) return W'((start + k) % NUM_PHYS);
    end
    return W'(start);
  endfunction

  initial begin
    model_reset();
    apply_reset();

    // idle after reset
    step(1'b0, 1'b0, '0);

    // drain: 32 grants then one refused request on empty
    for (int i = 0; i < 33; i++) step(1'b1, 1'b0, '0);

    // release into empty list, then grant it
    step(1'b0, 1'b1, W'(5));
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // simultaneous grant and release, then drain to see p7 at the tail
    apply_reset();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, W'(7));
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, '0);

    // double free, tag 0, overflow on a full list
    apply_reset();
    step(1'b0, 1'b1, W'(40));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, W'(0));
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, W'(5));
    step(1'b0, 1'b0, '0);
    // full list: grant and release together is legal
    step(1'b1, 1'b1, W'(5));
    step(1'b0, 1'b0, '0);

    // reset mid-operation
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, W'(NUM_ARCH + i));
    apply_reset();
    step(1'b0, 1'b0, '0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), pick_release());
    end
    step(1'b0, 1'b0, '0);

    @(negedge clk);
    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("stat_q_drained", stat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
